// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bundle: instruction-memory handshake, stage-3 redirect/stall
// inputs and IF/ID buffer load outputs.
interface fetch_ctrl_if #(parameter int CNT_W = 16);
  logic             imem_req;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      pc;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             mret;
  logic [31:0]      epc;
  logic             trap;
  logic [31:0]      trap_vec;
  logic             dmem_busy;
  logic             ifb_en;
  logic [31:0]      ifb_pc;
  logic [31:0]      ifb_inst;
  logic [1:0]       state;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output imem_req, pc, ifb_en, ifb_pc, ifb_inst, state, bubble_cnt,
    input  imem_ready, imem_rdata, br_taken, br_target, mret, epc,
           trap, trap_vec, dmem_busy
  );

  modport slave (
    input  imem_req, pc, ifb_en, ifb_pc, ifb_inst, state, bubble_cnt,
    output imem_ready, imem_rdata, br_taken, br_target, mret, epc,
           trap, trap_vec, dmem_busy
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC and imem handshake, feeds the IF/ID buffer with
// instructions or NOP bubbles across redirects and data-memory stalls.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2} state_t;

  state_t           st_q, st_d;
  logic [31:0]      pc_q, pc_d, pend_q, pend_d;
  logic [31:0]      hold_q, hold_d, hold_pc_q, hold_pc_d;
  logic             hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] cnt_q;
  logic             req, en, bubble, redirect;
  logic [31:0]      ipc, iinst, target;

  // trap outranks the stall; mret/branch only act when the pipeline moves
  assign redirect = bus.trap | (~bus.dmem_busy & (bus.mret | bus.br_taken));
  assign target   = bus.trap ? bus.trap_vec : (bus.mret ? bus.epc : bus.br_target);

  always_comb begin
    st_d       = st_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    hold_d     = hold_q;
    hold_pc_d  = hold_pc_q;
    hold_vld_d = hold_vld_q;
    req        = 1'b0;
    en         = 1'b0;
    bubble     = 1'b0;
    ipc        = pc_q;
    iinst      = NOP;
    case (st_q)
      RUN: begin
        req = 1'b1;
        if (redirect) begin
          en     = 1'b1;
          bubble = 1'b1;
          if (bus.imem_ready) begin
            pc_d = target;
          end else begin
            pend_d = target;
            st_d   = DRAIN;
          end
        end else if (bus.dmem_busy) begin
          bubble = 1'b1;
          if (bus.imem_ready) begin
            hold_d     = bus.imem_rdata;
            hold_pc_d  = pc_q;
            hold_vld_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
          st_d = STALL;
        end else begin
          en = 1'b1;
          if (bus.imem_ready) begin
            iinst = bus.imem_rdata;
            pc_d  = pc_q + 32'd4;
          end else begin
            bubble = 1'b1;
          end
        end
      end
      STALL: begin
        req = ~hold_vld_q;
        if (bus.trap) begin
          en         = 1'b1;
          bubble     = 1'b1;
          hold_vld_d = 1'b0;
          if (!hold_vld_q && !bus.imem_ready) begin
            pend_d = bus.trap_vec;
            st_d   = DRAIN;
          end else begin
            pc_d = bus.trap_vec;
            st_d = RUN;
          end
        end else if (bus.dmem_busy) begin
          bubble = 1'b1;
          if (req && bus.imem_ready) begin
            hold_d     = bus.imem_rdata;
            hold_pc_d  = pc_q;
            hold_vld_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end else begin
          en   = 1'b1;
          st_d = RUN;
          if (hold_vld_q) begin
            iinst      = hold_q;
            ipc        = hold_pc_q;
            hold_vld_d = 1'b0;
          end else if (bus.imem_ready) begin
            iinst = bus.imem_rdata;
            pc_d  = pc_q + 32'd4;
          end else begin
            bubble = 1'b1;
          end
        end
      end
      DRAIN: begin
        req    = 1'b1;
        en     = 1'b1;
        bubble = 1'b1;
        if (bus.trap) pend_d = bus.trap_vec;
        // the stale response is dropped; a coincident trap wins over pend_pc
        if (bus.imem_ready) begin
          pc_d = bus.trap ? bus.trap_vec : pend_q;
          st_d = RUN;
        end
      end
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= RUN;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      hold_q     <= 32'd0;
      hold_pc_q  <= 32'd0;
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      hold_pc_q  <= hold_pc_d;
      hold_vld_q <= hold_vld_d;
      if (bubble && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.imem_req   = req & ~rst;
  assign bus.ifb_en     = en & ~rst;
  assign bus.ifb_pc     = rst ? 32'd0 : ipc;
  assign bus.ifb_inst   = rst ? NOP : iinst;
  assign bus.pc         = pc_q;
  assign bus.state      = st_q;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; expected buffer loads are queued as stimulus
// is driven and checked whenever the DUT asserts ifb_en.
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [1:0]  RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2;
  localparam int          K_NONE = 0, K_NOP = 1, K_DATA = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          chk_pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_bub = 0;
  exp_t sb[$];

  fetch_ctrl_if #(.CNT_W(16)) bus();

  fetch_ctrl #(.RESET_PC(32'h0), .NOP(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ifb_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_load", bus.ifb_inst, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ifb_inst", bus.ifb_inst, e.inst);
        if (e.chk_pc) chk("ifb_pc", bus.ifb_pc, e.pc);
      end
    end
  end

  // one cycle: drive imem response, queue the expected load, check at negedge
  task automatic cyc(input logic rdy, input logic [31:0] rd, input logic [31:0] exp_pc,
                     input logic [1:0] exp_st, input int kind, input logic [31:0] ld_pc,
                     input logic exp_req);
    exp_t e;
    bus.imem_ready = rdy;
    bus.imem_rdata = rd;
    if (kind == K_NOP) begin
      e.pc = 32'd0; e.inst = NOP; e.chk_pc = 1'b0; sb.push_back(e);
    end else if (kind == K_DATA) begin
      e.pc = ld_pc; e.inst = mk(ld_pc); e.chk_pc = 1'b1; sb.push_back(e);
    end
    @(negedge clk);
    chk("pc", bus.pc, exp_pc);
    chk("state", {30'd0, bus.state}, {30'd0, exp_st});
    chk("bubble_cnt", {16'd0, bus.bubble_cnt}, exp_bub);
    chk("ifb_en", {31'd0, bus.ifb_en}, (kind != K_NONE) ? 32'd1 : 32'd0);
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
    if (kind != K_DATA) exp_bub++;
    @(posedge clk);
    #1;
  endtask

  task automatic ok(input logic [31:0] a);
    cyc(1'b1, mk(a), a, RUN, K_DATA, a, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_ifb_en"}, {31'd0, bus.ifb_en}, 32'd0);
    chk({tag, "_ifb_pc"}, bus.ifb_pc, 32'd0);
    chk({tag, "_ifb_inst"}, bus.ifb_inst, NOP);
    chk({tag, "_pc"}, bus.pc, 32'd0);
    chk({tag, "_state"}, {30'd0, bus.state}, 32'd0);
    chk({tag, "_bubble_cnt"}, {16'd0, bus.bubble_cnt}, 32'd0);
  endtask

  initial begin
    bus.imem_ready = 1'b1; bus.imem_rdata = DB;
    bus.br_taken = 1'b0;   bus.br_target = 32'd0;
    bus.mret = 1'b0;       bus.epc = 32'd0;
    bus.trap = 1'b0;       bus.trap_vec = 32'd0;
    bus.dmem_busy = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // streaming, then two wait cycles at pc=8
    ok(32'h0); ok(32'h4);
    cyc(1'b0, DB, 32'h8, RUN, K_NOP, 32'h0, 1'b1);
    cyc(1'b0, DB, 32'h8, RUN, K_NOP, 32'h0, 1'b1);
    ok(32'h8); ok(32'hC);

    // branch while fetch outstanding; late response for 0x10 must be dropped
    bus.br_taken = 1'b1; bus.br_target = 32'h100;
    cyc(1'b0, DB, 32'h10, RUN, K_NOP, 32'h0, 1'b1);
    bus.br_taken = 1'b0;
    cyc(1'b0, DB, 32'h10, DRAIN, K_NOP, 32'h0, 1'b1);
    cyc(1'b0, DB, 32'h10, DRAIN, K_NOP, 32'h0, 1'b1);
    cyc(1'b1, mk(32'h10), 32'h10, DRAIN, K_NOP, 32'h0, 1'b1);
    ok(32'h100);

    // branch with ready in the same cycle: single bubble
    bus.br_taken = 1'b1; bus.br_target = 32'h20;
    cyc(1'b1, mk(32'h104), 32'h104, RUN, K_NOP, 32'h0, 1'b1);
    bus.br_taken = 1'b0;

    // dmem_busy for 4 cycles, fetch of 0x20 completing in the second
    bus.dmem_busy = 1'b1;
    cyc(1'b0, DB, 32'h20, RUN, K_NONE, 32'h0, 1'b1);
    cyc(1'b1, mk(32'h20), 32'h20, STALL, K_NONE, 32'h0, 1'b1);
    cyc(1'b1, DB, 32'h24, STALL, K_NONE, 32'h0, 1'b0);
    cyc(1'b1, DB, 32'h24, STALL, K_NONE, 32'h0, 1'b0);
    bus.dmem_busy = 1'b0;
    cyc(1'b0, DB, 32'h24, STALL, K_DATA, 32'h20, 1'b0);
    ok(32'h24);

    // trap beats a simultaneous branch and dmem stall
    bus.trap = 1'b1; bus.trap_vec = 32'h80;
    bus.br_taken = 1'b1; bus.br_target = 32'h200; bus.dmem_busy = 1'b1;
    cyc(1'b1, mk(32'h28), 32'h28, RUN, K_NOP, 32'h0, 1'b1);
    bus.trap = 1'b0; bus.br_taken = 1'b0; bus.dmem_busy = 1'b0;
    ok(32'h80);

    // trap into DRAIN, then a newer trap replaces the pending vector
    bus.trap = 1'b1; bus.trap_vec = 32'h80;
    cyc(1'b0, DB, 32'h84, RUN, K_NOP, 32'h0, 1'b1);
    bus.trap_vec = 32'hC0;
    cyc(1'b0, DB, 32'h84, DRAIN, K_NOP, 32'h0, 1'b1);
    bus.trap = 1'b0;
    cyc(1'b1, mk(32'h84), 32'h84, DRAIN, K_NOP, 32'h0, 1'b1);
    ok(32'hC0);

    // trap in STALL with a held instruction discards it
    bus.dmem_busy = 1'b1;
    cyc(1'b1, mk(32'hC4), 32'hC4, RUN, K_NONE, 32'h0, 1'b1);
    bus.trap = 1'b1; bus.trap_vec = 32'h300;
    cyc(1'b0, DB, 32'hC8, STALL, K_NOP, 32'h0, 1'b0);
    bus.trap = 1'b0; bus.dmem_busy = 1'b0;
    ok(32'h300);

    // mret redirect
    bus.mret = 1'b1; bus.epc = 32'h400;
    cyc(1'b1, mk(32'h304), 32'h304, RUN, K_NOP, 32'h0, 1'b1);
    bus.mret = 1'b0;
    ok(32'h400);

    // reset while STALL holds an instruction
    bus.dmem_busy = 1'b1;
    cyc(1'b1, mk(32'h404), 32'h404, RUN, K_NONE, 32'h0, 1'b1);
    chk("stall_before_rst", {30'd0, bus.state}, {30'd0, STALL});
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_bub = 0;
    bus.dmem_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ok(32'h0); ok(32'h4);

    // pc+4 wraps past the top of the address space
    bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
    cyc(1'b1, mk(32'h8), 32'h8, RUN, K_NOP, 32'h0, 1'b1);
    bus.br_taken = 1'b0;
    ok(32'hFFFF_FFFC);
    ok(32'h0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
